canny_tile_host: RTL and testbench

Tile-sequencing host controller that drives the CannyEdge register-file port as its initiator. It copies an 8x8 pixel tile from a source image memory into the CannyEdge register window and issues a fixed sequence of operations. It then reads the 8x8 result window back and writes it to a destination memory, walking the whole image tile by tile. It runs on the CannyEdge clock domain (tclk) and replaces the hand-written stimulus sequencing used for bring-up.

---
 rtl/canny_tile_host.sv | 235 +++++++++++++++++++++++
 tb/tb_canny_tile_host.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/canny_tile_host.sv
// Tile-sequencing initiator for the CannyEdge register port: loads each 8x8 tile,
// issues NUM_OPS operation strobes, reads the result window back to destination memory.
module canny_tile_host #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128,
  parameter int NUM_OPS    = 4,
  parameter int OP_WAIT    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0] src_rdata,
  output logic                  dst_we,
  output logic [ADDR_WIDTH-1:0] dst_addr,
  output logic [DATA_WIDTH-1:0] dst_wdata,
  output logic [2:0]            dAddrRegRow,
  output logic [2:0]            dAddrRegCol,
  output logic                  bCE,
  output logic                  bWE,
  output logic [DATA_WIDTH-1:0] InData,
  input  logic [DATA_WIDTH-1:0] OutData,
  output logic [2:0]            OPMode,
  output logic                  bOPEnable,
  output logic [3:0]            dReadReg,
  output logic [3:0]            dWriteReg
);

  localparam int TX_N = IMG_W / 8;
  localparam int TY_N = IMG_H / 8;
  localparam int TXW  = $clog2(TX_N + 1);
  localparam int TYW  = $clog2(TY_N + 1);
  localparam int WW   = $clog2(OP_WAIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_WAIT, S_READ, S_NEXT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [6:0]      k_q, k_d;
  logic [3:0]      step_q, step_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [TXW-1:0]  tx_q, tx_d;
  logic [TYW-1:0]  ty_q, ty_d;

  logic                  busy_q, busy_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0] src_addr_q, src_addr_d, dst_addr_q, dst_addr_d;
  logic                  dst_we_q, dst_we_d, ld_wr_q, ld_wr_d;
  logic [DATA_WIDTH-1:0] indata_q, dwdata_q;
  logic [2:0]            row_q, row_d, col_q, col_d, opm_q, opm_d;
  logic                  bce_q, bce_d, bwe_q, bwe_d, bop_q, bop_d;
  logic [3:0]            rdr_q, rdr_d, wrr_q, wrr_d;
  logic [5:0]            km1;

  function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [TXW-1:0] tx,
                                                     input logic [TYW-1:0] ty,
                                                     input logic [5:0] k);
    logic [31:0] a;
    a = (32'(ty) * 32'd8 + 32'(k[5:3])) * 32'(IMG_W) + 32'(tx) * 32'd8 + 32'(k[2:0]);
    return a[ADDR_WIDTH-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    step_d  = step_q;
    wcnt_d  = wcnt_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        k_d     = 7'd0;
        tx_d    = '0;
        ty_d    = '0;
      end
      S_LOAD: if (k_q == 7'd64) begin
        state_d = S_RUN;
        step_d  = 4'd0;
      end else k_d = k_q + 7'd1;
      S_RUN: begin
        state_d = S_WAIT;
        wcnt_d  = '0;
      end
      S_WAIT: if (wcnt_q == WW'(OP_WAIT - 1)) begin
        if (step_q == 4'(NUM_OPS - 1)) begin
          state_d = S_READ;
          k_d     = 7'd0;
        end else begin
          state_d = S_RUN;
          step_d  = step_q + 4'd1;
        end
      end else wcnt_d = wcnt_q + WW'(1);
      S_READ: if (k_q == 7'd64) state_d = S_NEXT;
              else k_d = k_q + 7'd1;
      S_NEXT: begin
        k_d = 7'd0;
        if (tx_q == TXW'(TX_N - 1)) begin
          tx_d = '0;
          if (ty_q == TYW'(TY_N - 1)) state_d = S_DONE;
          else begin
            ty_d    = ty_q + TYW'(1);
            state_d = S_LOAD;
          end
        end else begin
          tx_d    = tx_q + TXW'(1);
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they can be registered and
  // still line up with the cycle they belong to.
  always_comb begin
    km1        = k_d[5:0] - 6'd1;
    busy_d     = (state_d inside {S_LOAD, S_RUN, S_WAIT, S_READ, S_NEXT});
    done_d     = (state_d == S_DONE);
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    dst_we_d   = 1'b0;
    ld_wr_d    = 1'b0;
    row_d      = row_q;
    col_d      = col_q;
    bce_d      = 1'b1;
    bwe_d      = 1'b1;
    bop_d      = 1'b1;
    opm_d      = opm_q;
    rdr_d      = rdr_q;
    wrr_d      = wrr_q;
    unique case (state_d)
      S_LOAD: begin
        if (k_d < 7'd64) src_addr_d = pix_addr(tx_d, ty_d, k_d[5:0]);
        if (k_d != 7'd0) begin
          bce_d   = 1'b0;
          bwe_d   = 1'b0;
          ld_wr_d = 1'b1;
          row_d   = km1[5:3];
          col_d   = km1[2:0];
        end
      end
      S_RUN: begin
        bop_d = 1'b0;
        opm_d = step_d[2:0];
        rdr_d = step_d;
        wrr_d = step_d + 4'd1;
      end
      S_READ: begin
        if (k_d < 7'd64) begin
          bce_d = 1'b0;
          row_d = k_d[5:3];
          col_d = k_d[2:0];
        end
        if (k_d != 7'd0) begin
          dst_we_d   = 1'b1;
          dst_addr_d = pix_addr(tx_d, ty_d, km1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      step_q     <= '0;
      wcnt_q     <= '0;
      tx_q       <= '0;
      ty_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      dst_we_q   <= 1'b0;
      ld_wr_q    <= 1'b0;
      indata_q   <= '0;
      dwdata_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      bce_q      <= 1'b1;
      bwe_q      <= 1'b1;
      bop_q      <= 1'b1;
      opm_q      <= '0;
      rdr_q      <= '0;
      wrr_q      <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      step_q     <= step_d;
      wcnt_q     <= wcnt_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      dst_we_q   <= dst_we_d;
      ld_wr_q    <= ld_wr_d;
      indata_q   <= InData;
      dwdata_q   <= dst_wdata;
      row_q      <= row_d;
      col_q      <= col_d;
      bce_q      <= bce_d;
      bwe_q      <= bwe_d;
      bop_q      <= bop_d;
      opm_q      <= opm_d;
      rdr_q      <= rdr_d;
      wrr_q      <= wrr_d;
    end
  end

  // Memory and register read data arrive one cycle late, so the write-data
  // outputs pass them straight through during the write cycle and hold after.
  assign InData      = ld_wr_q  ? src_rdata : indata_q;
  assign dst_wdata   = dst_we_q ? OutData   : dwdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign src_addr    = src_addr_q;
  assign dst_we      = dst_we_q;
  assign dst_addr    = dst_addr_q;
  assign dAddrRegRow = row_q;
  assign dAddrRegCol = col_q;
  assign bCE         = bce_q;
  assign bWE         = bwe_q;
  assign OPMode      = opm_q;
  assign bOPEnable   = bop_q;
  assign dReadReg    = rdr_q;
  assign dWriteReg   = wrr_q;

endmodule

// File: tb/tb_canny_tile_host.sv
// Bench for canny_tile_host on a 16x16 image: source memory and CannyEdge
// register models, dst-write scoreboard, op-strobe and protocol monitor.
module tb_canny_tile_host;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, dst_we, bCE, bWE, bOPEnable;
  logic [15:0] src_addr, dst_addr;
  logic [7:0]  src_rdata, dst_wdata, InData, OutData;
  logic [2:0]  dAddrRegRow, dAddrRegCol, OPMode;
  logic [3:0]  dReadReg, dWriteReg;

  canny_tile_host #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .IMG_W(16), .IMG_H(16),
                    .NUM_OPS(4), .OP_WAIT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .src_addr(src_addr), .src_rdata(src_rdata),
    .dst_we(dst_we), .dst_addr(dst_addr), .dst_wdata(dst_wdata),
    .dAddrRegRow(dAddrRegRow), .dAddrRegCol(dAddrRegCol),
    .bCE(bCE), .bWE(bWE), .InData(InData), .OutData(OutData),
    .OPMode(OPMode), .bOPEnable(bOPEnable), .dReadReg(dReadReg), .dWriteReg(dWriteReg));

  always #5 clk = ~clk;

  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int wr_cnt = 0, rw_cnt = 0, op_cnt = 0, done_cnt = 0, done_cyc = 0, last_op = 0;
  logic done_busy = 1'b0, prev_rd = 1'b0;
  logic [7:0] regs [8][8];

  function automatic logic [7:0] src_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Source memory with one-cycle read latency; CannyEdge register file whose
  // read data carries a position-dependent offset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    src_rdata <= src_val(src_addr);
    if (!bCE && !bWE) regs[dAddrRegRow][dAddrRegCol] <= InData;
    if (!bCE && bWE) OutData <= regs[dAddrRegRow][dAddrRegCol] + {2'b00, dAddrRegRow, dAddrRegCol};
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("ce_op_overlap", {31'd0, !bCE && !bOPEnable}, 32'd0);
      check("we_without_ce", {31'd0, !bWE && bCE}, 32'd0);
      check("dst_lag", {31'd0, dst_we}, {31'd0, prev_rd});
      if (dst_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) check("dst_unexpected", 32'd1, 32'd0);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          check("dst_addr", {16'd0, dst_addr}, {16'd0, e.a});
          check("dst_data", {24'd0, dst_wdata}, {24'd0, e.d});
        end
      end
      if (!bCE && !bWE) rw_cnt++;
      if (!bOPEnable) begin
        check("opmode", {29'd0, OPMode}, 32'(op_cnt % 4));
        check("readreg", {28'd0, dReadReg}, 32'(op_cnt % 4));
        check("writereg", {28'd0, dWriteReg}, 32'(op_cnt % 4 + 1));
        if (op_cnt % 4 != 0) check("op_spacing", 32'(cyc - last_op), 32'd5);
        last_op = cyc;
        op_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_busy = busy;
      end
      prev_rd = !bCE && bWE;
    end else prev_rd = 1'b0;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input int npix);
    int n = 0;
    for (int ty = 0; ty < 2; ty++)
      for (int tx = 0; tx < 2; tx++)
        for (int k = 0; k < 64; k++) begin
          wr_t e;
          e.a = 16'((ty * 8 + k / 8) * 16 + tx * 8 + k % 8);
          e.d = src_val(e.a) + 8'(k);
          if (n < npix) exp_q.push_back(e);
          n++;
        end
  endtask

  task automatic wait_done(input int prev, input string tag);
    int n = 0;
    while (done_cnt == prev && n < 3000) begin
      step();
      n++;
    end
    if (done_cnt == prev) check(tag, 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_bce"}, {31'd0, bCE}, 32'd1);
    check({tag, "_bwe"}, {31'd0, bWE}, 32'd1);
    check({tag, "_bop"}, {31'd0, bOPEnable}, 32'd1);
    check({tag, "_dstwe"}, {31'd0, dst_we}, 32'd0);
    check({tag, "_addrs"}, {src_addr, dst_addr}, 32'd0);
    check({tag, "_data"}, {16'd0, InData, dst_wdata}, 32'd0);
    check({tag, "_rowcol_op"}, {20'd0, dAddrRegRow, dAddrRegCol, OPMode, 3'd0}, 32'd0);
    check({tag, "_planes"}, {24'd0, dReadReg, dWriteReg}, 32'd0);
  endtask

  initial begin
    int c0, d1, n;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) step();
    check_reset_vals("reset");
    reset = 1'b0;
    step();

    // Pass 1: single start pulse, a stray start at cycle 50 must be ignored.
    push_exp(256);
    start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0;
    step();
    check("c1_busy", {31'd0, busy}, 32'd1);
    check("c1_src_addr", {16'd0, src_addr}, 32'd0);
    check("c1_bce", {31'd0, bCE}, 32'd1);
    step();
    check("c2_write", {30'd0, bCE, bWE}, 32'd0);
    check("c2_indata", {24'd0, InData}, {24'd0, src_val(16'd0)});
    check("c2_src_addr", {16'd0, src_addr}, 32'd1);
    while (cyc < c0 + 49) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(0, "pass1_timeout");
    check("pass1_done_cycle", 32'(done_cyc - c0), 32'd604);
    check("pass1_done_busy", {31'd0, done_busy}, 32'd0);
    repeat (5) step();
    check("pass1_done_count", 32'(done_cnt), 32'd1);
    check("pass1_busy_after", {31'd0, busy}, 32'd0);
    check("pass1_writes", 32'(wr_cnt), 32'd256);
    check("pass1_regwrites", 32'(rw_cnt), 32'd256);
    check("pass1_ops", 32'(op_cnt), 32'd16);
    check("pass1_queue", 32'(exp_q.size()), 32'd0);

    // Back-to-back passes with start held high.
    push_exp(256);
    push_exp(256);
    start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    wait_done(1, "pass2_timeout");
    check("pass2_done_cycle", 32'(done_cyc - c0), 32'd604);
    d1 = done_cyc;
    repeat (3) step();
    start = 1'b0;
    wait_done(2, "pass3_timeout");
    check("b2b_gap", 32'(done_cyc - d1), 32'd606);
    repeat (10) step();
    check("b2b_done_count", 32'(done_cnt), 32'd3);
    check("b2b_idle", {31'd0, busy}, 32'd0);
    check("b2b_writes", 32'(wr_cnt), 32'd768);
    check("b2b_queue", 32'(exp_q.size()), 32'd0);

    // Reset mid-READ of tile 0 at pixel 10.
    push_exp(10);
    start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0;
    n = 0;
    while (cyc != c0 + 95 && n < 200) begin
      step();
      n++;
    end
    check("midread_reached", 32'(cyc - c0), 32'd95);
    #1;
    reset = 1'b1;
    #1;
    check_reset_vals("midreset");
    repeat (3) step();
    reset = 1'b0;
    repeat (200) step();
    check("post_reset_writes", 32'(wr_cnt), 32'd778);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    check("post_reset_queue", 32'(exp_q.size()), 32'd0);
    check("post_reset_dones", 32'(done_cnt), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
